// File: rtl/rvbridge_pkg.sv
// Shared definitions for the raw-video <-> Avalon-ST Video bridge encoder and decoder:
// VIP packet type codes, FSM state encoding and control-packet helpers.
package rvbridge_pkg;

   localparam logic [3:0] TYPE_CTRL  = 4'hF;
   localparam logic [3:0] TYPE_VIDEO = 4'h0;

   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_CTRL = 4'b0010,
      ST_VHDR = 4'b0100,
      ST_DATA = 4'b1000
   } state_t;

   // Number of payload beats after the type beat of a control packet.
   function automatic int unsigned ctrl_beats(input int unsigned spb);
      return (9 + spb - 1) / spb;
   endfunction

   // Nibble k of the control payload: width[15:12]..width[3:0], height[15:12]..height[3:0], interlace.
   function automatic logic [3:0] ctrl_nibble(input logic [15:0] w, input logic [15:0] h,
                                              input logic [3:0] il, input int unsigned k);
      logic [3:0] n;
      n = '0;
      if (k < 4)
         n = 4'(w >> (4 * (3 - k)));
      else if (k < 8)
         n = 4'(h >> (4 * (7 - k)));
      else if (k == 8)
         n = il;
      return n;
   endfunction

endpackage

// File: rtl/rvbridge_out_reg.sv
// One-entry registered Avalon-ST output stage (data, sop, eop, valid/ready).
// A new beat is captured whenever the register is empty or being drained this cycle.
module rvbridge_out_reg #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          in_sop,
   input  logic          in_eop,
   output logic          load,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_sop,
   output logic          out_eop,
   input  logic          out_ready
);

   assign load = !out_valid | out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
      end else if (load) begin
         out_valid <= in_valid;
         out_data  <= in_data;
         out_sop   <= in_sop;
         out_eop   <= in_eop;
      end
   end

endmodule

// File: rtl/rvbridge_encode_ctrl.sv
// Raw-video to Avalon-ST Video encoder: per frame emits a VIP control packet (optionally only
// when the frame format changes), a video header beat and the pixel beats, with length checking.
module rvbridge_encode_ctrl #(
   parameter int BITS_PER_SYMBOL  = 8,
   parameter int SYMBOLS_PER_BEAT = 1,
   parameter int CTRL_ON_CHANGE   = 0
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [15:0]                                  video_width,
   input  logic [15:0]                                  video_height,
   input  logic [3:0]                                   video_interlaced,
   input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0]  din_data,
   input  logic                                         din_valid,
   output logic                                         din_ready,
   input  logic                                         din_startofpacket,
   input  logic                                         din_endofpacket,
   output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0]  dout_data,
   output logic                                         dout_valid,
   input  logic                                         dout_ready,
   output logic                                         dout_startofpacket,
   output logic                                         dout_endofpacket,
   output logic                                         ctrl_sent,
   output logic                                         frame_err
);
   import rvbridge_pkg::*;

   localparam int BPS = BITS_PER_SYMBOL;
   localparam int SPB = SYMBOLS_PER_BEAT;
   localparam int DW  = BPS * SPB;
   localparam int NB  = ctrl_beats(SPB);

   if (BITS_PER_SYMBOL < 4 || SYMBOLS_PER_BEAT < 1 || SYMBOLS_PER_BEAT > 4) begin : g_param_chk
      $error("rvbridge_encode_ctrl: BITS_PER_SYMBOL must be >= 4 and SYMBOLS_PER_BEAT 1..4");
   end

   state_t        state, state_nxt;
   logic [3:0]    cnt;
   logic [15:0]   w_s, h_s, last_w, last_h;
   logic [3:0]    il_s, last_il;
   logic          first_frame;
   logic [31:0]   pix_cnt, expected;
   logic          dup_sop;
   logic          ctrl_tag;
   logic          load;
   logic          o_valid, o_sop, o_eop;
   logic [DW-1:0] o_data;
   logic [DW-1:0] ctrl_payload;
   logic          ready_c;
   logic          sop_seen, skip_ctrl, last_ctrl, pix_acc, extra_sop;

   for (genvar s = 0; s < SPB; s++) begin : g_sym
      assign ctrl_payload[s*BPS +: BPS] =
         BPS'(ctrl_nibble(w_s, h_s, il_s, (32'(cnt) - 32'd1) * 32'(SPB) + 32'(s)));
   end

   assign sop_seen  = din_valid & din_startofpacket;
   assign skip_ctrl = (CTRL_ON_CHANGE != 0) && !first_frame && (video_width == last_w) &&
                      (video_height == last_h) && (video_interlaced == last_il);
   assign last_ctrl = (cnt == 4'(NB));
   assign pix_acc   = (state == ST_DATA) && load && din_valid;
   assign extra_sop = din_startofpacket && (pix_cnt != '0);

   // The first beat of a packet is issued straight from IDLE so it reaches dout one cycle after SOP.
   always_comb begin
      state_nxt = state;
      ready_c   = 1'b0;
      o_valid   = 1'b0;
      o_data    = '0;
      o_sop     = 1'b0;
      o_eop     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            ready_c = din_valid & !din_startofpacket;
            if (sop_seen) begin
               o_valid = 1'b1;
               o_sop   = 1'b1;
               if (skip_ctrl) begin
                  o_data = DW'(TYPE_VIDEO);
                  if (load) state_nxt = ST_DATA;
               end else begin
                  o_data = DW'(TYPE_CTRL);
                  if (load) state_nxt = ST_CTRL;
               end
            end
         end
         ST_CTRL: begin
            o_valid = 1'b1;
            o_data  = ctrl_payload;
            o_eop   = last_ctrl;
            if (load && last_ctrl) state_nxt = ST_VHDR;
         end
         ST_VHDR: begin
            o_valid = 1'b1;
            o_sop   = 1'b1;
            o_data  = DW'(TYPE_VIDEO);
            if (load) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            ready_c = load;
            o_valid = din_valid;
            o_data  = din_data;
            o_eop   = din_endofpacket;
            if (load && din_valid && din_endofpacket) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign din_ready = ready_c & !rst;
   assign ctrl_sent = dout_valid & dout_ready & ctrl_tag;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         w_s         <= '0;
         h_s         <= '0;
         il_s        <= '0;
         last_w      <= '0;
         last_h      <= '0;
         last_il     <= '0;
         first_frame <= 1'b1;
         expected    <= '0;
         pix_cnt     <= '0;
         dup_sop     <= 1'b0;
         ctrl_tag    <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         frame_err <= 1'b0;
         if (state == ST_IDLE && sop_seen) begin
            w_s      <= video_width;
            h_s      <= video_height;
            il_s     <= video_interlaced;
            expected <= 32'(video_width) * 32'(video_height);
            cnt      <= 4'd1;
         end
         if (state == ST_CTRL && load) begin
            cnt <= cnt + 4'd1;
            if (last_ctrl) begin
               last_w      <= w_s;
               last_h      <= h_s;
               last_il     <= il_s;
               first_frame <= 1'b0;
            end
         end
         if (load)
            ctrl_tag <= (state == ST_CTRL) && last_ctrl;
         if (state != ST_DATA) begin
            pix_cnt <= '0;
            dup_sop <= 1'b0;
         end else if (pix_acc) begin
            pix_cnt <= pix_cnt + 32'd1;
            if (extra_sop) dup_sop <= 1'b1;
            if (din_endofpacket)
               frame_err <= ((pix_cnt + 32'd1) != expected) || dup_sop || extra_sop;
         end
      end
   end

   rvbridge_out_reg #(.DW(DW)) u_out (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (o_valid),
      .in_data   (o_data),
      .in_sop    (o_sop),
      .in_eop    (o_eop),
      .load      (load),
      .out_valid (dout_valid),
      .out_data  (dout_data),
      .out_sop   (dout_startofpacket),
      .out_eop   (dout_endofpacket),
      .out_ready (dout_ready)
   );

endmodule

// File: tb/tb_rvbridge_encode_ctrl.sv
// Bench for rvbridge_encode_ctrl: three configurations share one stimulus bus, a packet-level
// model predicts every output beat, ctrl_sent and frame_err; literal checks pin the model.
module tb_rvbridge_encode_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] vw, vh;
   logic [3:0]  vil;
   logic [23:0] din_data;
   logic        din_valid, din_sop, din_eop, dout_ready;
   logic [1:0]  sel;
   bit          stall_en;
   bit          rst_q;

   logic        r1, v1, s1, e1, cs1, fe1;
   logic [7:0]  d1;
   logic        r3, v3, s3, e3, cs3, fe3;
   logic [23:0] d3;
   logic        rc, vc, sc, ec, csc, fec;
   logic [7:0]  dc;

   logic        m_ready, m_valid, m_sop, m_eop, m_cs, m_fe;
   logic [23:0] m_data;

   typedef struct packed {
      logic [23:0] d;
      logic        sop;
      logic        eop;
      logic        cl;
   } beat_t;

   beat_t       exp_q[$];
   bit          err_q[$];
   logic [23:0] obs[$];
   bit          first[3];
   logic [15:0] lw[3], lh[3];
   logic [3:0]  lil[3];
   int          n_cmp = 0, n_bad = 0;
   int          cs_cnt = 0, fe_cnt = 0, fseed = 0;

   always #5 clk = ~clk;

   rvbridge_encode_ctrl #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(1), .CTRL_ON_CHANGE(0)) u1 (
      .clk(clk), .rst(rst), .video_width(vw), .video_height(vh), .video_interlaced(vil),
      .din_data(din_data[7:0]), .din_valid(din_valid & (sel == 2'd0)), .din_ready(r1),
      .din_startofpacket(din_sop), .din_endofpacket(din_eop),
      .dout_data(d1), .dout_valid(v1), .dout_ready(dout_ready),
      .dout_startofpacket(s1), .dout_endofpacket(e1), .ctrl_sent(cs1), .frame_err(fe1));

   rvbridge_encode_ctrl #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3), .CTRL_ON_CHANGE(0)) u3 (
      .clk(clk), .rst(rst), .video_width(vw), .video_height(vh), .video_interlaced(vil),
      .din_data(din_data), .din_valid(din_valid & (sel == 2'd1)), .din_ready(r3),
      .din_startofpacket(din_sop), .din_endofpacket(din_eop),
      .dout_data(d3), .dout_valid(v3), .dout_ready(dout_ready),
      .dout_startofpacket(s3), .dout_endofpacket(e3), .ctrl_sent(cs3), .frame_err(fe3));

   rvbridge_encode_ctrl #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(1), .CTRL_ON_CHANGE(1)) uc (
      .clk(clk), .rst(rst), .video_width(vw), .video_height(vh), .video_interlaced(vil),
      .din_data(din_data[7:0]), .din_valid(din_valid & (sel == 2'd2)), .din_ready(rc),
      .din_startofpacket(din_sop), .din_endofpacket(din_eop),
      .dout_data(dc), .dout_valid(vc), .dout_ready(dout_ready),
      .dout_startofpacket(sc), .dout_endofpacket(ec), .ctrl_sent(csc), .frame_err(fec));

   always_comb begin
      case (sel)
         2'd1:    {m_ready, m_valid, m_sop, m_eop, m_cs, m_fe, m_data} = {r3, v3, s3, e3, cs3, fe3, d3};
         2'd2:    {m_ready, m_valid, m_sop, m_eop, m_cs, m_fe, m_data} = {rc, vc, sc, ec, csc, fec, 16'h0, dc};
         default: {m_ready, m_valid, m_sop, m_eop, m_cs, m_fe, m_data} = {r1, v1, s1, e1, cs1, fe1, 16'h0, d1};
      endcase
   end

   always @(posedge clk) rst_q <= rst;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   function automatic logic [23:0] pix_val(input int i);
      logic [23:0] v;
      v = 24'(fseed * 32'h1F3 + i * 32'h3A5C7 + 32'h0B);
      return v & ((sel == 2'd1) ? 24'hFFFFFF : 24'h0000FF);
   endfunction

   // Packet-level prediction for one frame on the selected configuration.
   task automatic model_frame(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il,
                              input int npix, input int dup_at);
      int          spb, coc, nb, k;
      bit          need;
      logic [35:0] f;
      logic [3:0]  nib[9];
      logic [23:0] d;
      spb  = (sel == 2'd1) ? 3 : 1;
      coc  = (sel == 2'd2) ? 1 : 0;
      need = (coc == 0) || first[sel] || ({w, h, il} != {lw[sel], lh[sel], lil[sel]});
      if (need) begin
         f = {w, h, il};
         for (int j = 0; j < 9; j++) nib[j] = 4'(f >> (32 - 4 * j));
         nb = (9 + spb - 1) / spb;
         exp_q.push_back('{d: 24'h00000F, sop: 1'b1, eop: 1'b0, cl: 1'b0});
         for (int b = 1; b <= nb; b++) begin
            d = '0;
            for (int s = 0; s < spb; s++) begin
               k = (b - 1) * spb + s;
               if (k < 9) d = d | (24'(nib[k]) << (8 * s));
            end
            exp_q.push_back('{d: d, sop: 1'b0, eop: (b == nb), cl: (b == nb)});
         end
         lw[sel] = w; lh[sel] = h; lil[sel] = il; first[sel] = 1'b0;
      end
      exp_q.push_back('{d: 24'h0, sop: 1'b1, eop: 1'b0, cl: 1'b0});
      for (int i = 0; i < npix; i++)
         exp_q.push_back('{d: pix_val(i), sop: 1'b0, eop: (i == npix - 1), cl: 1'b0});
      err_q.push_back((npix != int'(32'(w) * 32'(h))) || (dup_at != 0));
   endtask

   task automatic send_frame(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il,
                             input int npix, input int dup_at, input int abort_at, input bit chk_lat);
      int waited;
      bit acc;
      fseed++;
      model_frame(w, h, il, npix, dup_at);
      vw = w; vh = h; vil = il;
      for (int i = 0; i < npix; i++) begin
         if (abort_at != 0 && i == abort_at) break;
         din_valid = 1'b1;
         din_sop   = (i == 0) || (dup_at != 0 && i == dup_at);
         din_eop   = (i == npix - 1);
         din_data  = pix_val(i);
         waited = 0;
         acc    = 1'b0;
         while (!acc) begin
            @(negedge clk);
            acc = m_ready;
            @(posedge clk);
            #1;
            if (chk_lat && i == 0 && waited == 0)
               chk("ctrl_sop_latency", 32'({m_valid, m_sop, m_data}), {6'h0, 2'b11, 24'h00000F});
            waited++;
            if (waited > 2000) begin
               chk("din_accept_timeout", 32'd1, 32'd0);
               din_valid = 1'b0;
               return;
            end
         end
      end
      din_valid = 1'b0;
      din_sop   = 1'b0;
      din_eop   = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || err_q.size() != 0) && t < 5000) begin
         @(posedge clk);
         t++;
      end
      if (t >= 5000) chk("drain_timeout", 32'd1, 32'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial forever @(posedge clk) begin
      #1;
      dout_ready = stall_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
   end

   // Per-cycle compare against the model.
   initial begin
      bit          pend_fe, prev_stall, exp_cs;
      logic [26:0] prev_word;
      beat_t       e;
      pend_fe    = 1'b0;
      prev_stall = 1'b0;
      prev_word  = '0;
      forever begin
         @(negedge clk);
         if (rst || rst_q) begin
            if (rst_q) chk("reset_dout_valid", 32'(m_valid), 32'd0);
            exp_q.delete();
            err_q.delete();
            pend_fe    = 1'b0;
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) chk("stall_hold", 32'({m_valid, m_sop, m_eop, m_data}), 32'(prev_word));
            exp_cs = 1'b0;
            if (m_valid && dout_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat", 32'({m_sop, m_eop, m_data}), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("dout_beat", 32'({m_sop, m_eop, m_data}), 32'({e.sop, e.eop, e.d}));
                  exp_cs = e.cl;
               end
               obs.push_back(m_data);
            end
            chk("ctrl_sent", 32'(m_cs), 32'(exp_cs));
            if (m_cs) cs_cnt++;
            chk("frame_err", 32'(m_fe), 32'(pend_fe));
            if (m_fe) fe_cnt++;
            pend_fe = 1'b0;
            if (din_valid && m_ready && din_eop) begin
               if (err_q.size() == 0) chk("unexpected_eop", 32'd1, 32'd0);
               else pend_fe = err_q.pop_front();
            end
            prev_stall = m_valid && !dout_ready;
            prev_word  = {m_valid, m_sop, m_eop, m_data};
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] t1[11];
      logic [23:0] t2[5];
      t1 = '{24'hF, 24'h0, 24'h7, 24'h8, 24'h0, 24'h0, 24'h4, 24'h3, 24'h8, 24'h0, 24'h0};
      t2 = '{24'h00000F, 24'h080200, 24'h010000, 24'h03000E, 24'h000000};
      for (int i = 0; i < 3; i++) begin
         first[i] = 1'b1; lw[i] = '0; lh[i] = '0; lil[i] = '0;
      end
      rst = 1'b1; sel = 2'd0; stall_en = 1'b0; dout_ready = 1'b1;
      vw = '0; vh = '0; vil = '0; din_data = '0; din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 32'({m_ready, m_valid, m_cs, m_fe}), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1080p progressive, short frame
      obs.delete(); fe_cnt = 0;
      send_frame(16'd1920, 16'd1080, 4'h0, 4, 0, 0, 1'b1);
      drain();
      chk("t1_beat_count", 32'(obs.size()), 32'd15);
      for (int i = 0; i < 11; i++) chk("t1_ctrl_beat", 32'(obs[i]), 32'(t1[i]));
      chk("t1_frame_err", 32'(fe_cnt), 32'd1);

      // three symbols per beat
      sel = 2'd1; obs.delete();
      send_frame(16'h0280, 16'h01E0, 4'h3, 2, 0, 0, 1'b0);
      drain();
      for (int i = 0; i < 5; i++) chk("t2_ctrl_beat", 32'(obs[i]), 32'(t2[i]));

      // random backpressure
      sel = 2'd0; stall_en = 1'b1; obs.delete(); fe_cnt = 0;
      send_frame(16'd16, 16'd2, 4'h0, 32, 0, 0, 1'b0);
      send_frame(16'd16, 16'd2, 4'h0, 32, 0, 0, 1'b0);
      drain();
      stall_en = 1'b0;
      chk("t3_beat_count", 32'(obs.size()), 32'd86);
      chk("t3_frame_err", 32'(fe_cnt), 32'd0);

      // control packet only on format change
      sel = 2'd2; obs.delete(); cs_cnt = 0;
      for (int f = 0; f < 3; f++) send_frame(16'd8, 16'd8, 4'h0, 64, 0, 0, 1'b0);
      send_frame(16'd8, 16'd4, 4'h0, 32, 0, 0, 1'b0);
      drain();
      chk("t4_ctrl_sent", 32'(cs_cnt), 32'd2);
      chk("t4_beat_count", 32'(obs.size()), 32'd248);

      // length errors, 1-pixel frame, second SOP
      sel = 2'd0; fe_cnt = 0;
      send_frame(16'd4, 16'd4, 4'h0, 12, 0, 0, 1'b0);
      send_frame(16'd4, 16'd4, 4'h0, 16, 0, 0, 1'b0);
      drain();
      chk("t5_frame_err", 32'(fe_cnt), 32'd1);
      send_frame(16'd1, 16'd1, 4'h0, 1, 0, 0, 1'b0);
      send_frame(16'd2, 16'd2, 4'h0, 4, 2, 0, 1'b0);
      drain();
      chk("t5_frame_err_total", 32'(fe_cnt), 32'd2);

      // reset mid-frame, junk, fresh frame
      sel = 2'd2;
      send_frame(16'd8, 16'd4, 4'h0, 32, 0, 6, 1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) first[i] = 1'b1;
      @(posedge clk);
      #1;
      for (int j = 0; j < 3; j++) begin
         din_valid = 1'b1; din_sop = 1'b0; din_eop = 1'b0; din_data = 24'(j + 5);
         @(negedge clk);
         chk("t6_junk_ready", 32'(m_ready), 32'd1);
         @(posedge clk);
         #1;
      end
      din_valid = 1'b0;
      obs.delete(); cs_cnt = 0;
      send_frame(16'd8, 16'd4, 4'h0, 32, 0, 0, 1'b0);
      drain();
      chk("t6_ctrl_sent", 32'(cs_cnt), 32'd1);
      chk("t6_first_beat", 32'(obs[0]), 32'h0F);
      chk("t6_beat_count", 32'(obs.size()), 32'd43);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
